// File: rtl/seq_link_pkg.sv
// seq_link_pkg: definitions shared by both ends of the "1011"-sync serial link.
//   state_e  : transmitter FSM states (3-bit encoding)
//   PREAMBLE : sync pattern, sent bit 3 first
//   PRE_LEN  : preamble length in bits
//   cnt_width: width of the bit counter for a given payload width
package seq_link_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        DATA = 3'd2,
        PAR  = 3'd3,
        GAP  = 3'd4
    } state_e;

    localparam logic [3:0] PREAMBLE = 4'b1011;
    localparam int         PRE_LEN  = 4;

    // The bit counter has to index both the preamble and the payload.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w > PRE_LEN ? data_w : PRE_LEN);
    endfunction

endpackage

// File: rtl/seq_tx_shifter.sv
// seq_tx_shifter: payload datapath of the serial transmitter.
// Loadable MSB-first shift register; with SEQ_TX_PARITY_EN defined it also
// accumulates even parity over the bits shifted out.
//   clk, rst_n : clock, async active-low reset
//   load       : capture data (takes priority over shift)
//   shift      : shift left by one, MSB leaves the register
//   data       : parallel payload word
//   msb        : current MSB, i.e. the next payload bit to transmit
//   parity     : XOR of all bits shifted out since the last load
//                (port exists only with SEQ_TX_PARITY_EN)
module seq_tx_shifter
    import seq_link_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] data,
    output logic              msb
`ifdef SEQ_TX_PARITY_EN
    ,
    output logic              parity
`endif
);

    logic [DATA_W-1:0] sreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= data;
        end else if (shift) begin
            sreg <= sreg << 1;
        end
    end

    assign msb = sreg[DATA_W-1];

`ifdef SEQ_TX_PARITY_EN
    // Every payload bit passes the MSB exactly once, so folding the MSB in
    // on each shift yields the parity of the whole word after DATA_W shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity <= 1'b0;
        end else if (load) begin
            parity <= 1'b0;
        end else if (shift) begin
            parity <= parity ^ sreg[DATA_W-1];
        end
    end
`endif

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial frame transmitter for the "1011"-sync link.
// Accepts a payload word over valid/ready, then emits one bit per clock:
// preamble 1011, payload MSB-first, optional even-parity bit, then an idle
// gap of GAP_CYC cycles before the next word is accepted.
// Optional feature macro: SEQ_TX_PARITY_EN (appends the parity bit).
//   clk, rst_n : clock, async active-low reset
//   in_data    : payload word, sampled on an accepted handshake
//   in_valid   : payload available
//   in_ready   : idle and able to accept (combinational from state)
//   tx_bit     : serial output bit (registered)
//   tx_en      : tx_bit carries a frame bit (registered)
//   busy       : not idle
//   frame_done : one-cycle pulse in the cycle after the last frame bit
module seq_pattern_tx #(
    parameter int         DATA_W   = 8,
    parameter int         GAP_CYC  = 2,
    parameter logic [3:0] PREAMBLE = seq_link_pkg::PREAMBLE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_bit,
    output logic              tx_en,
    output logic              busy,
    output logic              frame_done
);

    import seq_link_pkg::*;

    localparam int CNT_W = cnt_width(DATA_W);
    localparam int GAP_W = 4;

    state_e             state, state_nxt;
    logic [CNT_W-1:0]   bit_cnt, cnt_nxt, cnt_dec;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic               bit_nxt, en_nxt, done_nxt;
    logic               load, shift, fin, msb;
`ifdef SEQ_TX_PARITY_EN
    logic               parity;
`endif

    seq_tx_shifter #(.DATA_W(DATA_W)) u_shifter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .shift  (shift),
        .data   (in_data),
        .msb    (msb)
`ifdef SEQ_TX_PARITY_EN
        ,
        .parity (parity)
`endif
    );

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign cnt_dec  = bit_cnt - 1'b1;

    // The state register names the phase of the bit currently on tx_bit;
    // each transition computes the bit for the *next* cycle, so tx_bit and
    // tx_en come straight out of flops with no path from the inputs.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        gap_nxt   = gap_cnt;
        bit_nxt   = 1'b0;
        en_nxt    = 1'b0;
        done_nxt  = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        fin       = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    load      = 1'b1;
                    state_nxt = PRE;
                    cnt_nxt   = CNT_W'(PRE_LEN - 1);
                    bit_nxt   = PREAMBLE[PRE_LEN-1];
                    en_nxt    = 1'b1;
                end
            end
            PRE: begin
                en_nxt = 1'b1;
                if (bit_cnt != '0) begin
                    cnt_nxt = cnt_dec;
                    bit_nxt = PREAMBLE[cnt_dec[1:0]];
                end else begin
                    // Shifter was loaded on accept; its MSB is the first payload bit.
                    state_nxt = DATA;
                    cnt_nxt   = CNT_W'(DATA_W - 1);
                    bit_nxt   = msb;
                    shift     = 1'b1;
                end
            end
            DATA: begin
                if (bit_cnt != '0) begin
                    cnt_nxt = cnt_dec;
                    bit_nxt = msb;
                    en_nxt  = 1'b1;
                    shift   = 1'b1;
                end else begin
`ifdef SEQ_TX_PARITY_EN
                    // All payload bits have left the shifter by now.
                    state_nxt = PAR;
                    bit_nxt   = parity;
                    en_nxt    = 1'b1;
`else
                    fin = 1'b1;
`endif
                end
            end
`ifdef SEQ_TX_PARITY_EN
            PAR: begin
                fin = 1'b1;
            end
`endif
            GAP: begin
                if (gap_cnt != '0) begin
                    gap_nxt = gap_cnt - 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Last frame bit is on the wire: pulse done and enter the gap (or idle).
        if (fin) begin
            done_nxt = 1'b1;
            cnt_nxt  = '0;
            if (GAP_CYC > 0) begin
                state_nxt = GAP;
                gap_nxt   = GAP_W'(GAP_CYC - 1);
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            tx_bit     <= 1'b0;
            tx_en      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= cnt_nxt;
            gap_cnt    <= gap_nxt;
            tx_bit     <= bit_nxt;
            tx_en      <= en_nxt;
            frame_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: self-checking bench for seq_pattern_tx.
// Two instances: dut_a (GAP_CYC=2) and dut_b (GAP_CYC=0). A cycle-timeline
// model (queue of expected per-cycle outputs built from the frame layout)
// checks every cycle; table vectors and hand sequences cover corner cases.
module tb_seq_pattern_tx;

    localparam int GAP_A = 2;
    localparam int GAP_B = 0;
`ifdef SEQ_TX_PARITY_EN
    localparam int FL = 13;
`else
    localparam int FL = 12;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       iv_a, iv_b;
    logic [7:0] d_a, d_b;
    logic       rdy_a, tx_bit_a, tx_en_a, busy_a, done_a;
    logic       rdy_b, tx_bit_b, tx_en_b, busy_b, done_b;

    int n_cmp = 0;
    int n_bad = 0;

    seq_pattern_tx #(.DATA_W(8), .GAP_CYC(GAP_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(d_a), .in_valid(iv_a),
        .in_ready(rdy_a), .tx_bit(tx_bit_a), .tx_en(tx_en_a),
        .busy(busy_a), .frame_done(done_a)
    );

    seq_pattern_tx #(.DATA_W(8), .GAP_CYC(GAP_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(d_b), .in_valid(iv_b),
        .in_ready(rdy_b), .tx_bit(tx_bit_b), .tx_en(tx_en_b),
        .busy(busy_b), .frame_done(done_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // i-th bit of the frame carrying payload d
    function automatic logic fbit(input logic [7:0] d, input int i);
        logic [3:0] pre;
        pre = 4'b1011;
        if (i < 4)       return pre[3-i];
        else if (i < 12) return d[11-i];
        else             return ^d;
    endfunction

    // ---------------- timeline model ----------------
    typedef struct packed {
        logic en;
        logic b;
        logic done;
        logic rdy;
    } ent_t;
    localparam ent_t IDLE_E = 4'b0001;

    ent_t qa[$];
    ent_t qb[$];

    function automatic logic [4:0] expv(input ent_t e);
        return {e.rdy, ~e.rdy, e.en, e.b, e.done};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete();
        end else if (iv_a && (qa.size() == 0 || qa[0].rdy)) begin
            if (qa.size() != 0) void'(qa.pop_front());
            for (int i = 0; i < FL; i++) qa.push_back({1'b1, fbit(d_a, i), 2'b00});
            for (int g = 0; g < GAP_A; g++) qa.push_back({2'b00, (g == 0), 1'b0});
            if (GAP_A == 0) qa.push_back(4'b0011);
        end else if (qa.size() != 0) begin
            void'(qa.pop_front());
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qb.delete();
        end else if (iv_b && (qb.size() == 0 || qb[0].rdy)) begin
            if (qb.size() != 0) void'(qb.pop_front());
            for (int i = 0; i < FL; i++) qb.push_back({1'b1, fbit(d_b, i), 2'b00});
            for (int g = 0; g < GAP_B; g++) qb.push_back({2'b00, (g == 0), 1'b0});
            if (GAP_B == 0) qb.push_back(4'b0011);
        end else if (qb.size() != 0) begin
            void'(qb.pop_front());
        end
    end

    always @(negedge clk) begin
        chk("cycle_a", 32'({rdy_a, busy_a, tx_en_a, tx_bit_a, done_a}),
            32'(expv(qa.size() != 0 ? qa[0] : IDLE_E)));
        chk("cycle_b", 32'({rdy_b, busy_b, tx_en_b, tx_bit_b, done_b}),
            32'(expv(qb.size() != 0 ? qb[0] : IDLE_E)));
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]  data;
        logic [11:0] frm;   // preamble + payload, first bit in MSB
        logic        par;
    } tv_t;

    tv_t tab[6];

    task automatic send_frame(input tv_t t);
        logic [12:0] got, want;
        logic        en_all;
        int          n;
        got    = '0;
        en_all = 1'b1;
`ifdef SEQ_TX_PARITY_EN
        want = {t.frm, t.par};
`else
        want = {1'b0, t.frm};
`endif
        @(negedge clk); iv_a = 1'b1; d_a = t.data;
        @(negedge clk); iv_a = 1'b0; d_a = ~t.data;
        for (int i = 0; i < FL; i++) begin
            if (i != 0) @(negedge clk);
            got    = {got[11:0], tx_bit_a};
            en_all = en_all & tx_en_a;
        end
        chk("frame_bits", 32'({en_all, got}), 32'({1'b1, want}));
        @(negedge clk);
        chk("frame_done", 32'({done_a, tx_en_a}), 32'(2'b10));
        n = 1;
        while (!rdy_a && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ready_latency", 32'(n), 32'(GAP_A + 1));
    endtask

    initial begin
        int          n;
        logic        en_seen;
        logic [31:0] en_v, ex_en, bt_v, ex_bt, dn_v, ex_dn;

        tab[0] = '{8'hA5, 12'b1011_1010_0101, 1'b0};
        tab[1] = '{8'h01, 12'b1011_0000_0001, 1'b1};
        tab[2] = '{8'hFF, 12'b1011_1111_1111, 1'b0};
        tab[3] = '{8'h00, 12'b1011_0000_0000, 1'b0};
        tab[4] = '{8'h3C, 12'b1011_0011_1100, 1'b0};
        tab[5] = '{8'h80, 12'b1011_1000_0000, 1'b1};

        iv_a = 1'b0; iv_b = 1'b0; d_a = '0; d_b = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_state", 32'({rdy_a, tx_bit_a, tx_en_a, busy_a}), 32'(4'b1000));

        for (int t = 0; t < 6; t++) send_frame(tab[t]);

        // in_valid while busy is ignored
        @(negedge clk); iv_a = 1'b1; d_a = 8'h3C;
        @(negedge clk); iv_a = 1'b0;
        repeat (4) @(negedge clk);
        iv_a = 1'b1; d_a = 8'h55;
        repeat (2) @(negedge clk);
        iv_a = 1'b0;
        n = 0;
        while (!rdy_a && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("pulse_ready", 32'(rdy_a), 32'(1));
        en_seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            en_seen = en_seen | tx_en_a;
        end
        chk("no_extra_frame", 32'(en_seen), 32'(0));

        // reset during payload bit 3 (payload 0F, bit 3 is a 1)
        @(negedge clk); iv_a = 1'b1; d_a = 8'h0F;
        @(negedge clk); iv_a = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_reset_bit", 32'({tx_en_a, tx_bit_a}), 32'(2'b11));
        #1 rst_n = 1'b0;
        #1 chk("async_reset", 32'({tx_en_a, tx_bit_a, busy_a, done_a}), 32'(0));
        @(negedge clk); rst_n = 1'b1;
        n = 0;
        repeat (16) begin
            @(negedge clk);
            n += int'(done_a);
        end
        chk("no_done_after_reset", 32'(n), 32'(0));
        send_frame(tab[0]);

        // back-to-back on the zero-gap instance with in_valid held high
        @(negedge clk); iv_b = 1'b1; d_b = 8'hFF;
        en_v = '0; ex_en = '0; bt_v = '0; ex_bt = '0; dn_v = '0; ex_dn = '0;
        for (int j = 0; j < 2*FL+3; j++) begin
            @(negedge clk);
            if (j == 0) d_b = 8'h00;
            en_v[j] = tx_en_b;
            bt_v[j] = tx_bit_b;
            dn_v[j] = done_b;
            ex_en[j] = (j < FL) || (j > FL && j <= 2*FL);
            ex_dn[j] = (j == FL) || (j == 2*FL+1);
            if (j < FL)                    ex_bt[j] = fbit(8'hFF, j);
            else if (j > FL && j <= 2*FL)  ex_bt[j] = fbit(8'h00, j-FL-1);
            if (j == FL+1) iv_b = 1'b0;
        end
        chk("b2b_en", en_v, ex_en);
        chk("b2b_bits", bt_v, ex_bt);
        chk("b2b_done_pos", dn_v, ex_dn);
        chk("b2b_done_cnt", 32'($countones(dn_v)), 32'(2));

        // random traffic on both instances, checked by the timeline model
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            iv_a = ($urandom_range(0, 3) == 0);
            d_a  = 8'($urandom);
            iv_b = ($urandom_range(0, 2) == 0);
            d_b  = 8'($urandom);
        end
        @(negedge clk); iv_a = 1'b0; iv_b = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
